sys_ram: RTL and testbench
==========================

# sys_ram

Parametrised, cycle-accurate system-memory model for the ADMA testbench. It replaces the fixed 32-bit flat RAM with a word-organised array that has:
- configurable data width, depth and read latency;
- a valid/ready request port with byte enables;
- an error response for misaligned or out-of-range accesses;
- an optional ADMA descriptor table preloaded at reset.

It sits between the ADMA engine's system-bus master and the testbench. It is not synthesised into the SD host.

## Interface
- DATA_W, 32: data width in bits; 32 or 64.
- ADDR_W, 64: byte-address width.
- DEPTH, 32: number of DATA_W words; minimum 12 when the preload is enabled.
- READ_LAT, 1: cycles from request accept to response; range 1..4.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; writes only.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  access was misaligned or out of range.

## Operation
- Derived values:
  - BYTES = DATA_W/8
  - OFS = log2(BYTES)
  - word index = req_addr >> OFS
- Accept condition: req_valid && req_ready.
  - req_ready is 0 while RESET_N is low and 1 otherwise. There is no backpressure, so one request can be accepted per cycle.
- Error check (applies to reads and writes):
  - The request is in error if req_addr[OFS-1:0] != 0, or the word index ≥ DEPTH.
  - The index comparison uses the full ADDR_W; upper address bits are not truncated, so addresses do not wrap.
  - An error write leaves memory unchanged. An error read returns rdata 0.
- Write:
  - Byte lane i is updated with req_wdata[8i+7:8i] only where req_be[i]=1.
  - req_be=0 is a legal no-op and is still acknowledged with rsp_err=0.
- Read:
  - The word is sampled at the accepting edge, after any write accepted in an earlier cycle has taken effect.
  - There is one port, so a read and a write never share a cycle.
- Response path:
  - Every accepted request produces exactly one response, in order.
  - The response is delivered through a READ_LAT-deep shift pipeline carrying {valid, err, rdata}.
- Reset (asserted at any time, including mid-transaction):
  - All in-flight responses are discarded.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The memory array is re-initialised (see Configuration).

## Timing
- Request accepted at edge T; response visible after edge T+READ_LAT-1.
  - READ_LAT=1: rsp_valid is high in the cycle immediately following the accept edge.
- Back-to-back requests at edges T, T+1, T+2 produce rsp_valid for three consecutive cycles.
- Write at edge T, then read of the same address at edge T+1: the read returns the new data.
- rsp_valid is never held high for more than one cycle per request. No response stall exists.
- Release of RESET_N: req_ready rises combinationally. The first request can be accepted at the first rising edge with RESET_N high.

## Configuration
- Macro: ADMA_DESC_PRELOAD_EN.
- Defined: at reset, the array is cleared and then loaded with a three-descriptor ADMA2 table. Each descriptor occupies a 128-bit slot, shown here for DATA_W=32:
  - word0 = 0x00050011: length 5, tran, valid. words1–3 = 0 (read buffer at address 0).
  - word4 = 0x00050011. word5 = 0x00000040 (buffer at 64). words6–7 = 0.
  - word8 = 0x00000031: link, valid. words9–11 = 0 (link target 0).
  - For DATA_W=64, the same byte image is packed little-endian into 64-bit words.
- Not defined: all words reset to 0.

## Structure
- Package sys_ram_pkg holds:
  - descriptor attribute constants ATTR_VALID, ATTR_END, ATTR_INT, ACT_NOP, ACT_TRAN, ACT_LINK;
  - the descriptor slot size (16 bytes);
  - the preload image constants.
- One sub-module, sys_ram_rsp_pipe: a parametrised READ_LAT-stage delay line with async reset, carrying {valid, err, rdata}.

## Test plan
- Reset, then read address 0x0 with the preload macro defined → rsp_rdata=0x00050011, rsp_err=0. Read 0x14 → 0x00000040.
- READ_LAT=3: write 0xDEADBEEF to 0x8 with be=4'b1111, then read 0x8 on the next cycle → read rsp_valid exactly 3 cycles after its accept, rdata=0xDEADBEEF.
- Write 0x11223344 to 0x10 with be=4'b0101 over the existing 0xAABBCCDD → later read returns 0xAA22CC44.
- Read 0x2 (misaligned) and read DEPTH*4 (out of range) → rsp_err=1, rdata=0. A subsequent read of 0x0 is unaffected.
- Back-to-back read stream of 8 addresses → 8 consecutive rsp_valid cycles, data in order.
- RESET_N pulsed low while two reads are in flight (READ_LAT=4) → no rsp_valid appears after release, and memory shows the reset image.

Source files
------------

// File: rtl/sys_ram_pkg.sv
// Shared constants for sys_ram: ADMA2 descriptor attribute encodings and the
// descriptor table image loaded at reset when ADMA_DESC_PRELOAD_EN is defined.
package sys_ram_pkg;

    localparam int SLOT_BYTES = 16;

    localparam logic [7:0] ATTR_VALID = 8'h01;
    localparam logic [7:0] ATTR_END   = 8'h02;
    localparam logic [7:0] ATTR_INT   = 8'h04;
    localparam logic [7:0] ACT_NOP    = 8'h00;
    localparam logic [7:0] ACT_TRAN   = 8'h10;
    localparam logic [7:0] ACT_LINK   = 8'h30;

    // Descriptor word layout: length in [31:16], attributes in [7:0].
    localparam logic [31:0] DESC0_ATTR = {16'd5, 8'h00, ACT_TRAN | ATTR_VALID};
    localparam logic [31:0] DESC0_ADDR = 32'h0000_0000;
    localparam logic [31:0] DESC1_ATTR = {16'd5, 8'h00, ACT_TRAN | ATTR_VALID};
    localparam logic [31:0] DESC1_ADDR = 32'h0000_0040;
    localparam logic [31:0] DESC2_ATTR = {16'd0, 8'h00, ACT_LINK | ATTR_VALID};
    localparam logic [31:0] DESC2_ADDR = 32'h0000_0000;

    localparam int PRELOAD_WORDS32 = 3 * SLOT_BYTES / 4;

    function automatic logic [31:0] preload_word32(input int idx);
        logic [31:0] w;
        case (idx)
            0:       w = DESC0_ATTR;
            1:       w = DESC0_ADDR;
            4:       w = DESC1_ATTR;
            5:       w = DESC1_ADDR;
            8:       w = DESC2_ATTR;
            9:       w = DESC2_ADDR;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // 64-bit words pack the same byte image little-endian.
    function automatic logic [63:0] preload_word(input int idx, input int data_w);
        logic [63:0] w;
        if (data_w == 64) begin
            w = {preload_word32(2 * idx + 1), preload_word32(2 * idx)};
        end else begin
            w = {32'h0, preload_word32(idx)};
        end
        return w;
    endfunction

endpackage

// File: rtl/sys_ram_rsp_pipe.sv
// READ_LAT-stage delay line for {valid, err, rdata}; reset discards in-flight
// responses.
module sys_ram_rsp_pipe #(
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              next_valid,
    input  logic              next_err,
    input  logic [DATA_W-1:0] next_rdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata
);

    logic [DATA_W+1:0] stage [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= {next_valid, next_err, next_rdata};
            for (int i = 1; i < LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign {rsp_valid, rsp_err, rsp_rdata} = stage[LAT-1];

endmodule

// File: rtl/sys_ram.sv
// Word-organised system memory model with byte enables, error responses and
// fixed read latency. Define ADMA_DESC_PRELOAD_EN to load an ADMA2 table at reset.
module sys_ram
    import sys_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 64,
    parameter int DEPTH    = 32,
    parameter int READ_LAT = 1
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              addr_err;
    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    assign req_ready = RESET_N;
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr >> OFS;
    assign idx       = word_idx[IDX_W-1:0];

    // Full-width index compare so high addresses never alias into the array.
    assign addr_err  = (req_addr[OFS-1:0] != '0) || (word_idx >= ADDR_W'(DEPTH));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef ADMA_DESC_PRELOAD_EN
                mem[i] <= DATA_W'(preload_word(i, DATA_W));
`else
                mem[i] <= '0;
`endif
            end
        end else if (accept && req_we && !addr_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (accept && !req_we && !addr_err) begin
            rd_word = mem[idx];
        end
    end

    sys_ram_rsp_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_rsp_pipe (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .next_valid (accept),
        .next_err   (accept && addr_err),
        .next_rdata (rd_word),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata)
    );

endmodule

// File: tb/tb_sys_ram.sv
// Self-checking bench for sys_ram: queue-based response model plus a flat
// byte-lane memory model; honours ADMA_DESC_PRELOAD_EN for the reset image.
module tb_sys_ram;

    localparam int DW    = 32;
    localparam int AW    = 64;
    localparam int DEPTH = 32;
    localparam int LAT   = 3;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    sys_ram #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .READ_LAT (LAT)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic [31:0] mm [DEPTH];
    exp_t        q [$];

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
`ifdef ADMA_DESC_PRELOAD_EN
        mm[0] = 32'h0005_0011;
        mm[4] = 32'h0005_0011;
        mm[5] = 32'h0000_0040;
        mm[8] = 32'h0000_0031;
`endif
        q.delete();
    endfunction

    // Drive one cycle of request; model computes the expected response.
    task automatic issue(input logic v, input logic we, input logic [63:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        int   ix;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        if (v && RESET_N) begin
            e.due  = cyc + LAT;
            e.err  = (a[1:0] != 2'b00) || ((a >> 2) >= 64'(DEPTH));
            e.data = 32'h0;
            if (!e.err) begin
                ix = int'(a >> 2);
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mm[ix][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    e.data = mm[ix];
                end
            end
            q.push_back(e);
        end
        @(posedge CLK);
        cyc++;
        #1 req_valid = 1'b0;
    endtask

    task automatic expect_now(output logic ev, output logic ee, output logic [31:0] ed);
        ev = 1'b0; ee = 1'b0; ed = 32'h0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = 1'b1; ee = q[0].err; ed = q[0].data;
            void'(q.pop_front());
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        model_reset();
        #2;
        total++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: ready=%b v=%b e=%b d=%h, want 0 0 0 0", req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: ready=%b want 1", req_ready);
        end
    endtask

    task automatic test_preload();
        logic ev, ee; logic [31:0] ed;
        logic [63:0] addrs [6] = '{64'h0, 64'h14, 64'h20, 64'h4, 64'h10, 64'h24};
        for (int i = 0; i < 6 + LAT; i++) begin
            if (i < 6) issue(1'b1, 1'b0, addrs[i], 32'h0, 4'h0);
            else       issue(1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
            @(negedge CLK);
            expect_now(ev, ee, ed);
            total++;
            if (rsp_valid !== ev || (ev && (rsp_err !== ee || rsp_rdata !== ed))) begin
                bad++;
                $display("FAIL preload cyc=%0d: v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid, rsp_err, rsp_rdata, ev, ee, ed);
            end
        end
    endtask

    task automatic test_latency();
        logic ev, ee; logic [31:0] ed;
        int p, found;
        found = -1;
        issue(1'b1, 1'b1, 64'h8, 32'hDEAD_BEEF, 4'hF);
        @(negedge CLK);
        expect_now(ev, ee, ed);
        issue(1'b1, 1'b0, 64'h8, 32'h0, 4'h0);
        p = cyc;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge CLK);
            expect_now(ev, ee, ed);
            total++;
            if (rsp_valid !== ev || (ev && (rsp_err !== ee || rsp_rdata !== ed))) begin
                bad++;
                $display("FAIL latency_stream cyc=%0d: v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid, rsp_err, rsp_rdata, ev, ee, ed);
            end
            if (found < 0 && rsp_valid === 1'b1 && rsp_rdata === 32'hDEAD_BEEF) found = cyc - p;
            issue(1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
        end
        total++;
        if (found != LAT - 1) begin
            bad++;
            $display("FAIL read_latency: edges after accept=%0d want %0d", found, LAT - 1);
        end
    endtask

    task automatic test_partial_be();
        logic ev, ee; logic [31:0] ed;
        logic        v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        w [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] d [5] = '{32'hAABB_CCDD, 32'h1122_3344, 32'h0, 32'h0, 32'h0};
        logic [3:0]  e [5] = '{4'hF, 4'h5, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 5 + LAT; i++) begin
            if (i < 5) issue(v[i], w[i], 64'h10, d[i], e[i]);
            else       issue(1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
            @(negedge CLK);
            expect_now(ev, ee, ed);
            total++;
            if (rsp_valid !== ev || (ev && (rsp_err !== ee || rsp_rdata !== ed))) begin
                bad++;
                $display("FAIL partial_be cyc=%0d: v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid, rsp_err, rsp_rdata, ev, ee, ed);
            end
            if (ev && !w[0] && 1'b0) bad++;
        end
        total++;
        if (mm[4] !== 32'hAA22_CC44) begin
            bad++;
            $display("FAIL partial_be_model: model word=%h want aa22cc44", mm[4]);
        end
    endtask

    task automatic test_errors();
        logic ev, ee; logic [31:0] ed;
        logic        w [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] a [7] = '{64'h2, 64'(DEPTH * 4), 64'h8000_0000_0000_0000,
                               64'h6, 64'(DEPTH * 4), 64'h4, 64'h0};
        for (int i = 0; i < 7 + LAT; i++) begin
            if (i < 7) issue(1'b1, w[i], a[i], 32'h5A5A_5A5A, 4'hF);
            else       issue(1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
            @(negedge CLK);
            expect_now(ev, ee, ed);
            total++;
            if (rsp_valid !== ev || (ev && (rsp_err !== ee || rsp_rdata !== ed))) begin
                bad++;
                $display("FAIL errors cyc=%0d: v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid, rsp_err, rsp_rdata, ev, ee, ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ev, ee; logic [31:0] ed;
        int run;
        for (int i = 0; i < 8 + LAT; i++) begin
            if (i < 8) issue(1'b1, 1'b1, 64'(32 + 4 * i), $urandom, 4'hF);
            else       issue(1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
            @(negedge CLK);
            expect_now(ev, ee, ed);
            total++;
            if (rsp_valid !== ev || (ev && (rsp_err !== ee || rsp_rdata !== ed))) begin
                bad++;
                $display("FAIL b2b_write cyc=%0d: v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid, rsp_err, rsp_rdata, ev, ee, ed);
            end
        end
        run = 0;
        for (int i = 0; i < 8 + LAT; i++) begin
            if (i < 8) issue(1'b1, 1'b0, 64'(32 + 4 * i), 32'h0, 4'h0);
            else       issue(1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
            @(negedge CLK);
            expect_now(ev, ee, ed);
            if (rsp_valid === 1'b1) run++;
            total++;
            if (rsp_valid !== ev || (ev && (rsp_err !== ee || rsp_rdata !== ed))) begin
                bad++;
                $display("FAIL b2b_read cyc=%0d: v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid, rsp_err, rsp_rdata, ev, ee, ed);
            end
        end
        total++;
        if (run != 8) begin
            bad++;
            $display("FAIL b2b_count: valid cycles=%0d want 8", run);
        end
    endtask

    task automatic test_random();
        logic ev, ee; logic [31:0] ed;
        logic [63:0] a;
        int sel;
        for (int i = 0; i < 80 + LAT; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = 64'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else if (sel == 1) a = 64'(4 * (DEPTH + $urandom_range(0, 100)));
            else               a = 64'(4 * $urandom_range(0, DEPTH - 1));
            if (i < 80) issue($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, 4'($urandom));
            else        issue(1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
            @(negedge CLK);
            expect_now(ev, ee, ed);
            total++;
            if (rsp_valid !== ev || (ev && (rsp_err !== ee || rsp_rdata !== ed))) begin
                bad++;
                $display("FAIL random cyc=%0d: v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid, rsp_err, rsp_rdata, ev, ee, ed);
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic ev, ee; logic [31:0] ed;
        issue(1'b1, 1'b0, 64'h8, 32'h0, 4'h0);
        @(negedge CLK);
        expect_now(ev, ee, ed);
        issue(1'b1, 1'b0, 64'h10, 32'h0, 4'h0);
        @(negedge CLK);
        RESET_N = 1'b0;
        model_reset();
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_midflight: v=%b d=%h e=%b ready=%b want 0", rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        repeat (2) issue(1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 3 + LAT + 3; i++) begin
            if (i < 3) issue(1'b1, 1'b0, 64'(8 * i), 32'h0, 4'h0);
            else       issue(1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
            @(negedge CLK);
            expect_now(ev, ee, ed);
            total++;
            if (rsp_valid !== ev || (ev && (rsp_err !== ee || rsp_rdata !== ed))) begin
                bad++;
                $display("FAIL reset_release cyc=%0d: v=%b e=%b d=%h want v=%b e=%b d=%h", cyc, rsp_valid, rsp_err, rsp_rdata, ev, ee, ed);
            end
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover_responses: pending=%0d want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_latency();
        test_partial_be();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
